cpu_mc: RTL and testbench

Multi-cycle 16-bit processor core, successor to the single-cycle core: same 16-bit instruction encoding and 8-entry register file, but a registered fetch/execute state machine and a memory port that tolerates wait states (`i_mem_waitrequest`) and a configurable read latency. It sits between the system memory (or an interconnect) and nothing else: one shared instruction/data port, one request at a time.

---
 rtl/cpu_mc.sv | 267 ++++++++++++++++++++++++++
 tb/tb_cpu_mc.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mc.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_mc
//  Purpose  : Multi-cycle 16-bit processor core. It has one shared
//             instruction/data memory port and issues one request at a time.
//             The port tolerates wait states, and read data returns a fixed
//             MEM_RD_LAT edges after the request is accepted.
//
//  Ports    : clk               - clock
//             reset             - asynchronous, active-high reset
//             o_mem_addr        - byte address of the current request
//             o_mem_rd          - read request (instruction fetch or load)
//             o_mem_wr          - write request (store)
//             o_mem_wrdata      - store data
//             i_mem_waitrequest - 1 = request not accepted this cycle
//             i_mem_rddata      - read data, sampled MEM_RD_LAT edges after
//                                 acceptance
//             o_pc              - PC of the instruction in flight
//             o_retire          - pulse in the last cycle of each instruction
//
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_mc #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter int unsigned MEM_RD_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] o_mem_addr,
    output logic        o_mem_rd,
    output logic        o_mem_wr,
    output logic [15:0] o_mem_wrdata,
    input  logic        i_mem_waitrequest,
    input  logic [15:0] i_mem_rddata,
    output logic [15:0] o_pc,
    output logic        o_retire
);

    // The latency counter runs 0 .. MEM_RD_LAT-1. The read data is valid on
    // the edge that closes the last count.
    localparam logic [2:0] c_lat_last = 3'(MEM_RD_LAT - 1);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_FWAIT = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_MWAIT = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] regs_q [8];
    logic [15:0] regs_d [8];
    logic        flag_n_q, flag_n_d;
    logic        flag_z_q, flag_z_d;
    logic [2:0]  lat_cnt_q, lat_cnt_d;
    // Data access captured in EXEC so that MEM/MWAIT hold stable values.
    logic [15:0] maddr_q, maddr_d;
    logic [15:0] mwdata_q, mwdata_d;
    logic        mstore_q, mstore_d;
    logic [2:0]  mrx_q, mrx_d;

    // Instruction decode
    logic [3:0]  w_op;
    logic        w_immf;
    logic [2:0]  w_rx;
    logic [2:0]  w_ry;
    logic [15:0] w_rx_val;
    logic [15:0] w_ry_val;
    logic [15:0] w_opb;
    logic [15:0] w_sum;
    logic [15:0] w_diff;
    logic [15:0] w_pc_plus2;
    logic [15:0] w_jtgt;

    logic [15:0] w_mem_addr;
    logic        w_mem_rd;
    logic        w_mem_wr;
    logic [15:0] w_mem_wrdata;
    logic        w_retire;

    assign w_op       = ir_q[3:0];
    assign w_immf     = ir_q[4];
    assign w_rx       = ir_q[7:5];
    assign w_ry       = ir_q[10:8];
    assign w_rx_val   = regs_q[w_rx];
    assign w_ry_val   = regs_q[w_ry];
    assign w_opb      = w_immf ? {{8{ir_q[15]}}, ir_q[15:8]} : w_ry_val;
    assign w_sum      = w_rx_val + w_opb;
    assign w_diff     = w_rx_val - w_opb;
    assign w_pc_plus2 = pc_q + 16'd2;
    // The immediate offset counts in instruction words, so it is shifted
    // left by one. The register form reads the old Rx, which makes
    // "call R7" jump to the previous R7.
    assign w_jtgt     = w_immf ? (w_pc_plus2 + {{4{ir_q[15]}}, ir_q[15:5], 1'b0})
                               : w_rx_val;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        regs_d       = regs_q;
        flag_n_d     = flag_n_q;
        flag_z_d     = flag_z_q;
        lat_cnt_d    = lat_cnt_q;
        maddr_d      = maddr_q;
        mwdata_d     = mwdata_q;
        mstore_d     = mstore_q;
        mrx_d        = mrx_q;
        w_mem_addr   = 16'h0000;
        w_mem_rd     = 1'b0;
        w_mem_wr     = 1'b0;
        w_mem_wrdata = 16'h0000;
        w_retire     = 1'b0;

        case (state_q)
            S_FETCH: begin
                w_mem_rd   = 1'b1;
                w_mem_addr = pc_q;
                if (!i_mem_waitrequest) begin
                    state_d   = S_FWAIT;
                    lat_cnt_d = 3'd0;
                end
            end

            S_FWAIT: begin
                if (lat_cnt_q == c_lat_last) begin
                    ir_d    = i_mem_rddata;
                    state_d = S_EXEC;
                end else begin
                    lat_cnt_d = lat_cnt_q + 3'd1;
                end
            end

            S_EXEC: begin
                state_d  = S_FETCH;
                pc_d     = w_pc_plus2;
                w_retire = 1'b1;
                case (w_op)
                    4'd0: regs_d[w_rx] = w_opb;
                    4'd1: begin
                        regs_d[w_rx] = w_sum;
                        flag_n_d     = w_sum[15];
                        flag_z_d     = (w_sum == 16'h0000);
                    end
                    4'd2: begin
                        regs_d[w_rx] = w_diff;
                        flag_n_d     = w_diff[15];
                        flag_z_d     = (w_diff == 16'h0000);
                    end
                    4'd3: begin
                        flag_n_d = w_diff[15];
                        flag_z_d = (w_diff == 16'h0000);
                    end
                    4'd4: begin
                        if (!w_immf) begin
                            maddr_d  = w_ry_val;
                            mstore_d = 1'b0;
                            mrx_d    = w_rx;
                            state_d  = S_MEM;
                            w_retire = 1'b0;
                        end
                    end
                    4'd5: begin
                        if (!w_immf) begin
                            maddr_d  = w_ry_val;
                            mwdata_d = w_rx_val;
                            mstore_d = 1'b1;
                            state_d  = S_MEM;
                            w_retire = 1'b0;
                        end
                    end
                    4'd6: begin
                        if (w_immf) begin
                            regs_d[w_rx] = {ir_q[15:8], w_rx_val[7:0]};
                        end
                    end
                    4'd8:  pc_d = w_jtgt;
                    4'd9:  if (flag_z_q) pc_d = w_jtgt;
                    4'd10: if (flag_n_q) pc_d = w_jtgt;
                    4'd12: begin
                        regs_d[7] = w_pc_plus2;
                        pc_d      = w_jtgt;
                    end
                    default: ;
                endcase
            end

            S_MEM: begin
                w_mem_addr = maddr_q;
                if (mstore_q) begin
                    w_mem_wr     = 1'b1;
                    w_mem_wrdata = mwdata_q;
                end else begin
                    w_mem_rd = 1'b1;
                end
                if (!i_mem_waitrequest) begin
                    if (mstore_q) begin
                        state_d  = S_FETCH;
                        w_retire = 1'b1;
                    end else begin
                        state_d   = S_MWAIT;
                        lat_cnt_d = 3'd0;
                    end
                end
            end

            S_MWAIT: begin
                if (lat_cnt_q == c_lat_last) begin
                    regs_d[mrx_q] = i_mem_rddata;
                    w_retire      = 1'b1;
                    state_d       = S_FETCH;
                end else begin
                    lat_cnt_d = lat_cnt_q + 3'd1;
                end
            end

            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= 16'h0000;
            flag_n_q  <= 1'b0;
            flag_z_q  <= 1'b0;
            lat_cnt_q <= 3'd0;
            maddr_q   <= 16'h0000;
            mwdata_q  <= 16'h0000;
            mstore_q  <= 1'b0;
            mrx_q     <= 3'd0;
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= 16'h0000;
            end
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            flag_n_q  <= flag_n_d;
            flag_z_q  <= flag_z_d;
            lat_cnt_q <= lat_cnt_d;
            maddr_q   <= maddr_d;
            mwdata_q  <= mwdata_d;
            mstore_q  <= mstore_d;
            mrx_q     <= mrx_d;
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // The state resets to FETCH. Gating with reset keeps the bus idle while
    // reset is held, and the first request appears in the first cycle after
    // reset is released.
    assign o_mem_addr   = reset ? 16'h0000 : w_mem_addr;
    assign o_mem_rd     = w_mem_rd & ~reset;
    assign o_mem_wr     = w_mem_wr & ~reset;
    assign o_mem_wrdata = reset ? 16'h0000 : w_mem_wrdata;
    assign o_retire     = w_retire & ~reset;
    assign o_pc         = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_mc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_mc
//  Purpose  : Scoreboard bench for cpu_mc. An instruction-level reference
//             model executes each program image and queues the expected bus
//             transactions and per-instruction cycle counts. A bus responder
//             and monitor process pops and compares these entries whenever
//             the core presents a request or a retire pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_mc;

    localparam int          LAT    = 3;
    localparam logic [15:0] RST_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_wrdata;
    logic        waitreq;
    logic [15:0] rddata;
    logic [15:0] pc_o;
    logic        retire;

    always #5 clk = ~clk;

    cpu_mc #(
        .RESET_PC   (RST_PC),
        .MEM_RD_LAT (LAT)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .o_mem_addr        (mem_addr),
        .o_mem_rd          (mem_rd),
        .o_mem_wr          (mem_wr),
        .o_mem_wrdata      (mem_wrdata),
        .i_mem_waitrequest (waitreq),
        .i_mem_rddata      (rddata),
        .o_pc              (pc_o),
        .o_retire          (retire)
    );

    // kind: 0 = instruction fetch, 1 = load read, 2 = store write
    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] addr;
        logic [15:0] data;
    } txn_t;

    txn_t        exp_q[$];
    int          ret_q[$];
    logic [15:0] mem [32768];   // memory seen by the core
    logic [15:0] mm  [32768];   // reference model's private copy
    logic [15:0] model_pc;
    int          checks    = 0;
    int          failures  = 0;
    int          retired   = 0;
    int          wait_mode = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push_txn(input logic [1:0] k, input logic [15:0] a, input logic [15:0] d);
        txn_t t;
        t.kind = k;
        t.addr = a;
        t.data = d;
        exp_q.push_back(t);
    endtask

    function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [2:0] rx, input logic [2:0] ry);
        return {5'b00000, ry, rx, 1'b0, op};
    endfunction

    function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [2:0] rx, input logic [7:0] imm);
        return {imm, rx, 1'b1, op};
    endfunction

    function automatic logic [15:0] enc_j(input logic [3:0] op, input logic [10:0] off);
        return {off, 1'b1, op};
    endfunction

    // Instruction-level reference: executes n instructions from mm.
    task automatic model_run(input int n);
        logic [15:0] rf [8];
        logic [15:0] pc, ir, a, b, r, off, tgt, npc;
        logic        fn, fz, immf;
        logic [3:0]  op;
        logic [2:0]  rx, ry;
        int          base;
        pc = RST_PC;
        fn = 1'b0;
        fz = 1'b0;
        for (int i = 0; i < 8; i++) rf[i] = 16'h0000;
        for (int k = 0; k < n; k++) begin
            ir = mm[pc[15:1]];
            push_txn(2'd0, pc, 16'h0000);
            op   = ir[3:0];
            immf = ir[4];
            rx   = ir[7:5];
            ry   = ir[10:8];
            a    = rf[rx];
            b    = immf ? {{8{ir[15]}}, ir[15:8]} : rf[ry];
            off  = {{5{ir[15]}}, ir[15:5]};
            npc  = pc + 16'd2;
            tgt  = immf ? (npc + off + off) : a;
            base = 2 + LAT;
            case (op)
                4'd0: rf[rx] = b;
                4'd1, 4'd2, 4'd3: begin
                    r  = (op == 4'd1) ? a + b : a - b;
                    fz = (r == 16'h0000);
                    fn = r[15];
                    if (op != 4'd3) rf[rx] = r;
                end
                4'd4: if (!immf) begin
                    push_txn(2'd1, b, 16'h0000);
                    rf[rx] = mm[b[15:1]];
                    base   = 3 + 2 * LAT;
                end
                4'd5: if (!immf) begin
                    push_txn(2'd2, b, a);
                    mm[b[15:1]] = a;
                    base = 3 + LAT;
                end
                4'd6:  if (immf) rf[rx] = {ir[15:8], a[7:0]};
                4'd8:  npc = tgt;
                4'd9:  if (fz) npc = tgt;
                4'd10: if (fn) npc = tgt;
                4'd12: begin
                    rf[7] = npc;
                    npc   = tgt;
                end
                default: ;
            endcase
            ret_q.push_back(base);
            pc = npc;
        end
        model_pc = pc;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd"}, 64'(mem_rd), 64'(0));
        check({tag, "_wr"}, 64'(mem_wr), 64'(0));
        check({tag, "_addr"}, 64'(mem_addr), 64'(0));
        check({tag, "_wrdata"}, 64'(mem_wrdata), 64'(0));
        check({tag, "_retire"}, 64'(retire), 64'(0));
        check({tag, "_pc"}, 64'(pc_o), 64'(RST_PC));
    endtask

    // Starts from reset held high and ends with reset asserted again.
    task automatic do_run(input string tag, input int n, input int wmode, input bit abort_fwait);
        int guard;
        exp_q.delete();
        ret_q.delete();
        retired = 0;
        for (int i = 0; i < 32768; i++) mm[i] = mem[i];
        model_run(n);
        if (abort_fwait) push_txn(2'd0, model_pc, 16'h0000);
        wait_mode = wmode;
        @(posedge clk);
        #1 reset = 1'b0;
        guard = 0;
        while (retired < n && guard < n * 64 + 64) begin
            @(posedge clk);
            guard++;
        end
        check({tag, "_retire_count"}, 64'(retired), 64'(n));
        if (abort_fwait) begin
            // Wait until the extra fetch is accepted so the core is in FWAIT.
            guard = 0;
            while (exp_q.size() != 0 && guard < 64) begin
                @(posedge clk);
                guard++;
            end
            check({tag, "_extra_fetch_seen"}, 64'(exp_q.size()), 64'(0));
        end
        #1 reset = 1'b1;
        #1;
        check_reset_outputs({tag, "_reset"});
        check({tag, "_txn_left"}, 64'(exp_q.size()), 64'(0));
        check({tag, "_retire_left"}, 64'(ret_q.size()), 64'(0));
    endtask

    // Bus responder and monitor
    initial begin : mon
        int          rd_pend;
        logic [15:0] rd_val;
        int          wait_left;
        bit          stalled;
        logic [33:0] prev;
        int          cyc;
        int          waits;
        int          base;
        logic        req;
        txn_t        t;
        rd_pend   = 0;
        rd_val    = 16'h0000;
        wait_left = 0;
        stalled   = 1'b0;
        prev      = '0;
        cyc       = 0;
        waits     = 0;
        waitreq   = 1'b0;
        rddata    = 16'h0000;
        forever begin
            @(negedge clk);
            if (reset) begin
                rd_pend   = 0;
                stalled   = 1'b0;
                cyc       = 0;
                waits     = 0;
                wait_left = 0;
                waitreq   = 1'b0;
                rddata    = 16'($urandom);
            end else begin
                // Drive read data only in the cycle before the sampling edge.
                if (rd_pend > 0) begin
                    rd_pend--;
                    rddata = (rd_pend == 0) ? rd_val : 16'($urandom);
                end else begin
                    rddata = 16'($urandom);
                end
                req = mem_rd | mem_wr;
                if (req && !stalled) begin
                    case (wait_mode)
                        1: begin
                            wait_left = int'($urandom_range(0, 3));
                            if (wait_left > 0) wait_left--;
                        end
                        2: wait_left = (exp_q.size() > 0 && exp_q[0].kind != 2'd0) ? 2 : 0;
                        default: wait_left = 0;
                    endcase
                end
                if (req) begin
                    waitreq = (wait_left > 0);
                    if (wait_left > 0) wait_left--;
                end else begin
                    waitreq = 1'($urandom_range(0, 1));
                end
                #1;
                cyc++;
                if (req) begin
                    check("rd_wr_exclusive", 64'(mem_rd & mem_wr), 64'(0));
                    if (stalled)
                        check("req_stable", 64'({mem_rd, mem_wr, mem_addr, mem_wrdata}), 64'(prev));
                    if (waitreq) begin
                        waits++;
                    end else if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_request: actual addr=%0h wr=%0b expected=none", mem_addr, mem_wr);
                    end else begin
                        t = exp_q.pop_front();
                        check("req_is_write", 64'(mem_wr), 64'(t.kind == 2'd2));
                        check("req_addr", 64'(mem_addr), 64'(t.addr));
                        if (t.kind == 2'd2) check("store_data", 64'(mem_wrdata), 64'(t.data));
                        if (t.kind == 2'd0) check("fetch_pc", 64'(pc_o), 64'(t.addr));
                    end
                    if (!waitreq) begin
                        if (mem_wr) begin
                            mem[mem_addr[15:1]] = mem_wrdata;
                        end else begin
                            rd_pend = LAT;
                            rd_val  = mem[mem_addr[15:1]];
                        end
                    end
                    stalled = waitreq;
                    prev    = {mem_rd, mem_wr, mem_addr, mem_wrdata};
                end else begin
                    stalled = 1'b0;
                end
                if (retire) begin
                    retired++;
                    if (ret_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_retire: actual=retire expected=none");
                    end else begin
                        base = ret_q.pop_front();
                        check("instr_cycles", 64'(cyc), 64'(base + waits));
                    end
                    cyc   = 0;
                    waits = 0;
                end
            end
        end
    end

    initial begin : stim
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");

        // Directed program: ALU, flags, st/ld with waits, branches, call/return.
        fill_random();
        mem[0]   = enc_i(4'd0, 3'd1, 8'h05);   // 0x00 mv   R1,#5
        mem[1]   = enc_i(4'd1, 3'd1, 8'hFA);   // 0x02 add  R1,#-6
        mem[2]   = enc_i(4'd6, 3'd2, 8'h01);   // 0x04 mvhi R2,#1
        mem[3]   = enc_r(4'd5, 3'd1, 3'd2);    // 0x06 st   R1,[R2]
        mem[4]   = enc_r(4'd4, 3'd3, 3'd2);    // 0x08 ld   R3,[R2]
        mem[5]   = enc_i(4'd0, 3'd5, 8'h34);   // 0x0A mv   R5,#0x34
        mem[6]   = enc_i(4'd6, 3'd5, 8'h12);   // 0x0C mvhi R5,#0x12
        mem[7]   = enc_r(4'd3, 3'd1, 3'd1);    // 0x0E cmp  R1,R1
        mem[8]   = enc_j(4'd9, 11'd3);         // 0x10 jz   #3
        mem[9]   = enc_i(4'd0, 3'd6, 8'hFF);   // 0x12 skipped
        mem[10]  = enc_i(4'd0, 3'd6, 8'hFF);   // 0x14 skipped
        mem[11]  = enc_i(4'd0, 3'd6, 8'hFF);   // 0x16 skipped
        mem[12]  = enc_j(4'd10, 11'd5);        // 0x18 jn   #5 (not taken)
        mem[13]  = enc_i(4'd6, 3'd5, 8'hAB);   // 0x1A mvhi R5,#0xAB
        mem[14]  = 16'h0007;                   // 0x1C opcode 7
        mem[15]  = enc_i(4'd6, 3'd4, 8'h02);   // 0x1E mvhi R4,#2
        mem[16]  = enc_r(4'd12, 3'd4, 3'd0);   // 0x20 call R4
        mem[17]  = enc_r(4'd5, 3'd5, 3'd2);    // 0x22 st   R5,[R2]
        mem[18]  = enc_r(4'd5, 3'd3, 3'd4);    // 0x24 st   R3,[R4]
        mem[19]  = enc_r(4'd5, 3'd6, 3'd2);    // 0x26 st   R6,[R2]
        mem[20]  = enc_j(4'd10, 11'd1);        // 0x28 jn   #1
        mem[256] = enc_r(4'd5, 3'd7, 3'd4);    // 0x200 st  R7,[R4]
        mem[257] = enc_r(4'd8, 3'd7, 3'd0);    // 0x202 j   R7
        do_run("directed", 20, 2, 1'b1);

        // After a reset taken in FWAIT, every register reads back as zero.
        fill_random();
        for (int i = 0; i < 8; i++) mem[i] = enc_r(4'd5, 3'(i), 3'd0);
        do_run("regdump", 8, 1, 1'b0);

        // PC wrap: jump to 0xFFFE, then fall through to 0x0000.
        fill_random();
        mem[0]     = enc_j(4'd8, 11'h7FE);
        mem[32767] = enc_i(4'd0, 3'd1, 8'h07);
        do_run("wrap", 5, 0, 1'b0);

        for (int r = 0; r < 4; r++) begin
            fill_random();
            do_run("random", 80, (r == 0) ? 0 : 1, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
